// File: rtl/controle_elevador.sv
// controle_elevador: 4-floor elevator core (SCAN call service, door timer, occupancy 0..3, display mux toggle).
// Latency: a call lands in pendentes on its sampling edge; the FSM reacts to it one edge later.
// Backpressure: none; calls are level-sampled every cycle and entrar/sair pulses outside the door window are dropped.
module controle_elevador #(
   parameter int TICKS_ANDAR   = 4,
   parameter int TICKS_PORTA   = 3,
   parameter int TICKS_DISPLAY = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] chamada,
   input  logic       entrar,
   input  logic       sair,
   output logic [1:0] andar,
   output logic       A,
   output logic       B,
   output logic       controle_Mux,
   output logic       porta_aberta,
   output logic       subindo,
   output logic       descendo,
   output logic [3:0] pendentes
);
   localparam int AW = (TICKS_ANDAR   > 1) ? $clog2(TICKS_ANDAR)   : 1;
   localparam int PW = (TICKS_PORTA   > 1) ? $clog2(TICKS_PORTA)   : 1;
   localparam int DW = (TICKS_DISPLAY > 1) ? $clog2(TICKS_DISPLAY) : 1;

   typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA} estado_t;

   estado_t       estado_q;
   logic          dir_q;        // 1 = up, 0 = down
   logic [1:0]    andar_q;
   logic [AW-1:0] viagem_q;
   logic [PW-1:0] porta_q;
   logic [DW-1:0] disp_q;
   logic          mux_q;
   logic [3:0]    pend_q, pend_d;
   logic [1:0]    pessoas_q, pessoas_d;

   logic          fim_viagem, fim_porta, entra_porta;
   logic          acima, abaixo, segue_prox, inverte_prox;
   logic [1:0]    andar_prox, andar_porta;
   logic [3:0]    mask_andar;

   function automatic logic ha_acima(input logic [3:0] p, input logic [1:0] f);
      logic [3:0] m;
      m = 4'b1110 << f;
      return |(p & m);
   endfunction

   function automatic logic ha_abaixo(input logic [3:0] p, input logic [1:0] f);
      logic [3:0] m;
      m = ~(4'b1111 << f);
      return |(p & m);
   endfunction

   // Next floor, door-entry detection and pending-call update (clear beats a same-floor set)
   always_comb begin
      fim_viagem = ((estado_q == SUBINDO) || (estado_q == DESCENDO)) &&
                   (viagem_q == AW'(TICKS_ANDAR - 1));
      fim_porta  = (porta_q == PW'(TICKS_PORTA - 1));
      andar_prox = andar_q;
      if ((estado_q == SUBINDO) && (andar_q != 2'd3))
         andar_prox = andar_q + 2'd1;
      else if ((estado_q == DESCENDO) && (andar_q != 2'd0))
         andar_prox = andar_q - 2'd1;
      acima        = ha_acima(pend_q, andar_q);
      abaixo       = ha_abaixo(pend_q, andar_q);
      segue_prox   = (estado_q == SUBINDO) ? ha_acima(pend_q, andar_prox) : ha_abaixo(pend_q, andar_prox);
      inverte_prox = (estado_q == SUBINDO) ? ha_abaixo(pend_q, andar_prox) : ha_acima(pend_q, andar_prox);
      andar_porta  = (estado_q == PARADO) ? andar_q : andar_prox;
      entra_porta  = ((estado_q == PARADO) && pend_q[andar_q]) || (fim_viagem && pend_q[andar_prox]);
      mask_andar   = 4'b0001 << andar_q;
      pend_d       = pend_q | (chamada & ~((estado_q == PORTA) ? mask_andar : 4'b0000));
      if (entra_porta)
         pend_d = pend_d & ~(4'b0001 << andar_porta);
   end

   // Occupancy changes only while the door is open; simultaneous entrar/sair cancel out
   always_comb begin
      pessoas_d = pessoas_q;
      if (estado_q == PORTA) begin
         if (entrar && !sair && (pessoas_q != 2'd3))
            pessoas_d = pessoas_q + 2'd1;
         else if (sair && !entrar && (pessoas_q != 2'd0))
            pessoas_d = pessoas_q - 2'd1;
      end
   end

   // Car FSM: floor position, direction, travel and door timers
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= PARADO;
         dir_q    <= 1'b1;
         andar_q  <= 2'd0;
         viagem_q <= '0;
         porta_q  <= '0;
      end else begin
         case (estado_q)
            PARADO: begin
               viagem_q <= '0;
               porta_q  <= '0;
               if (pend_q[andar_q]) begin
                  estado_q <= PORTA;
               end else if (acima) begin
                  estado_q <= SUBINDO;
                  dir_q    <= 1'b1;
               end else if (abaixo) begin
                  estado_q <= DESCENDO;
                  dir_q    <= 1'b0;
               end
            end
            SUBINDO, DESCENDO: begin
               porta_q <= '0;
               if (fim_viagem) begin
                  andar_q  <= andar_prox;
                  viagem_q <= '0;
                  if (pend_q[andar_prox]) begin
                     estado_q <= PORTA;
                  end else if (segue_prox) begin
                     estado_q <= estado_q;
                  end else if (inverte_prox) begin
                     estado_q <= (estado_q == SUBINDO) ? DESCENDO : SUBINDO;
                     dir_q    <= (estado_q == SUBINDO) ? 1'b0 : 1'b1;
                  end else begin
                     estado_q <= PARADO;
                  end
               end else begin
                  viagem_q <= viagem_q + 1'b1;
               end
            end
            PORTA: begin
               viagem_q <= '0;
               if (chamada[andar_q]) begin
                  porta_q <= '0;
               end else if (fim_porta) begin
                  porta_q <= '0;
                  if (dir_q && acima) begin
                     estado_q <= SUBINDO;
                  end else if (abaixo) begin
                     estado_q <= DESCENDO;
                     dir_q    <= 1'b0;
                  end else if (acima) begin
                     estado_q <= SUBINDO;
                     dir_q    <= 1'b1;
                  end else begin
                     estado_q <= PARADO;
                  end
               end else begin
                  porta_q <= porta_q + 1'b1;
               end
            end
            default: estado_q <= PARADO;
         endcase
      end
   end

   // Pending calls and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q    <= 4'b0000;
         pessoas_q <= 2'd0;
      end else begin
         pend_q    <= pend_d;
         pessoas_q <= pessoas_d;
      end
   end

   // Free-running display multiplex toggle, independent of the car
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q <= '0;
         mux_q  <= 1'b0;
      end else if (disp_q == DW'(TICKS_DISPLAY - 1)) begin
         disp_q <= '0;
         mux_q  <= ~mux_q;
      end else begin
         disp_q <= disp_q + 1'b1;
      end
   end

   assign andar        = andar_q;
   assign A            = pessoas_q[1];
   assign B            = pessoas_q[0];
   assign controle_Mux = mux_q;
   assign porta_aberta = (estado_q == PORTA);
   assign subindo      = (estado_q == SUBINDO);
   assign descendo     = (estado_q == DESCENDO);
   assign pendentes    = pend_q;
endmodule

// File: tb/tb_controle_elevador.sv
// tb_controle_elevador: directed scenarios followed by random traffic, checked against a behavioural model.
module tb_controle_elevador;
   localparam int TA = 4;
   localparam int TP = 3;
   localparam int TD = 8;

   localparam int IDLE = 0;
   localparam int UP   = 1;
   localparam int DOWN = 2;
   localparam int DOOR = 3;

   logic       clk;
   logic       reset;
   logic [3:0] chamada;
   logic       entrar, sair;
   logic [1:0] andar;
   logic       A, B, controle_Mux, porta_aberta, subindo, descendo;
   logic [3:0] pendentes;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state
   int         m_andar, m_pessoas, m_modo, m_rest, m_cyc;
   bit         m_sobe;
   logic [3:0] m_pend;

   controle_elevador #(.TICKS_ANDAR(TA), .TICKS_PORTA(TP), .TICKS_DISPLAY(TD)) dut (
      .clk(clk), .reset(reset), .chamada(chamada), .entrar(entrar), .sair(sair),
      .andar(andar), .A(A), .B(B), .controle_Mux(controle_Mux),
      .porta_aberta(porta_aberta), .subindo(subindo), .descendo(descendo),
      .pendentes(pendentes)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit ha_chamada(input logic [3:0] p, input int f, input bit para_cima);
      for (int i = 0; i < 4; i++)
         if ((para_cima ? (i > f) : (i < f)) && p[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic abre_porta(input int f);
      m_modo    = DOOR;
      m_rest    = TP;
      m_pend[f] = 1'b0;
   endtask

   // One clock edge of the reference elevator; decisions use the calls known before the edge
   task automatic modelo(input logic [3:0] ch, input logic en, input logic sa, input logic rst);
      logic [3:0] old;
      if (rst) begin
         m_andar = 0; m_pessoas = 0; m_modo = IDLE; m_rest = 0; m_cyc = 0;
         m_sobe = 1'b1; m_pend = 4'b0000;
         return;
      end
      m_cyc++;
      old = m_pend;
      if (m_modo == DOOR) begin
         if (en && !sa && m_pessoas < 3) m_pessoas++;
         else if (sa && !en && m_pessoas > 0) m_pessoas--;
      end
      for (int i = 0; i < 4; i++)
         if (ch[i] && !(m_modo == DOOR && i == m_andar)) m_pend[i] = 1'b1;
      case (m_modo)
         IDLE: begin
            if (old[m_andar]) abre_porta(m_andar);
            else if (ha_chamada(old, m_andar, 1'b1)) begin m_modo = UP;   m_sobe = 1'b1; m_rest = TA; end
            else if (ha_chamada(old, m_andar, 1'b0)) begin m_modo = DOWN; m_sobe = 1'b0; m_rest = TA; end
         end
         UP, DOWN: begin
            m_rest--;
            if (m_rest == 0) begin
               m_andar += (m_modo == UP) ? 1 : -1;
               if (old[m_andar]) abre_porta(m_andar);
               else if (ha_chamada(old, m_andar, m_modo == UP)) m_rest = TA;
               else if (ha_chamada(old, m_andar, m_modo != UP)) begin
                  m_modo = (m_modo == UP) ? DOWN : UP;
                  m_sobe = (m_modo == UP);
                  m_rest = TA;
               end else m_modo = IDLE;
            end
         end
         default: begin
            if (ch[m_andar]) m_rest = TP;
            else begin
               m_rest--;
               if (m_rest == 0) begin
                  if (m_sobe && ha_chamada(old, m_andar, 1'b1)) begin m_modo = UP; m_rest = TA; end
                  else if (ha_chamada(old, m_andar, 1'b0)) begin m_modo = DOWN; m_sobe = 1'b0; m_rest = TA; end
                  else if (ha_chamada(old, m_andar, 1'b1)) begin m_modo = UP; m_sobe = 1'b1; m_rest = TA; end
                  else m_modo = IDLE;
               end
            end
         end
      endcase
   endtask

   task automatic compara();
      chk("andar",     8'(andar),        8'(m_andar));
      chk("pendentes", 8'(pendentes),    8'(m_pend));
      chk("pessoas",   8'({A, B}),       8'(m_pessoas));
      chk("mux",       8'(controle_Mux), 8'((m_cyc / TD) % 2));
      chk("porta",     8'(porta_aberta), 8'(m_modo == DOOR));
      chk("subindo",   8'(subindo),      8'(m_modo == UP));
      chk("descendo",  8'(descendo),     8'(m_modo == DOWN));
   endtask

   task automatic ciclo(input logic [3:0] ch, input logic en, input logic sa, input logic rst);
      chamada = ch; entrar = en; sair = sa; reset = rst;
      @(posedge clk);
      modelo(ch, en, sa, rst);
      #1;
      compara();
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic aguarda_porta(input string tag);
      int n = 0;
      while (!porta_aberta && n < 100) begin ciclo(4'b0000, 1'b0, 1'b0, 1'b0); n++; end
      chk(tag, 8'(porta_aberta), 8'd1);
   endtask

   task automatic aguarda_fecha(input string tag);
      int n = 0;
      while (porta_aberta && n < 100) begin ciclo(4'b0000, 1'b0, 1'b0, 1'b0); n++; end
      chk(tag, 8'(porta_aberta), 8'd0);
   endtask

   initial begin
      chamada = 4'b0000; entrar = 1'b0; sair = 1'b0; reset = 1'b1;
      ciclo(4'b0000, 1'b0, 1'b0, 1'b1);
      chk("rst_andar", 8'(andar), 8'd0);
      chk("rst_pend",  8'(pendentes), 8'd0);

      // 1: idle, display toggles at cycles 8 and 16
      for (int i = 1; i <= 20; i++) begin
         ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
         if (i == 7)  chk("t1_mux7",  8'(controle_Mux), 8'd0);
         if (i == 8)  chk("t1_mux8",  8'(controle_Mux), 8'd1);
         if (i == 16) chk("t1_mux16", 8'(controle_Mux), 8'd0);
      end

      // 2: single call to floor 2
      ciclo(4'b0100, 1'b0, 1'b0, 1'b0);
      chk("t2_pend", 8'(pendentes), 8'b0100);
      chk("t2_sub0", 8'(subindo), 8'd0);
      ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("t2_sub1", 8'(subindo), 8'd1);
      ocioso(3);
      chk("t2_f0", 8'(andar), 8'd0);
      ocioso(1);
      chk("t2_f1", 8'(andar), 8'd1);
      ocioso(4);
      chk("t2_f2", 8'(andar), 8'd2);
      chk("t2_porta", 8'(porta_aberta), 8'd1);
      chk("t2_clr", 8'(pendentes), 8'd0);
      ocioso(2);
      chk("t2_porta2", 8'(porta_aberta), 8'd1);
      ocioso(1);
      chk("t2_fecha", 8'({porta_aberta, subindo, descendo}), 8'd0);

      // 4: door restart by a same-floor call
      ciclo(4'b0100, 1'b0, 1'b0, 1'b0);
      ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("t4_abre", 8'(porta_aberta), 8'd1);
      ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
      ciclo(4'b0100, 1'b0, 1'b0, 1'b0);
      chk("t4_pend", 8'(pendentes), 8'd0);
      ocioso(2);
      chk("t4_aberta", 8'(porta_aberta), 8'd1);
      ocioso(1);
      chk("t4_fecha", 8'(porta_aberta), 8'd0);

      // 5: occupancy saturation, door held open by same-floor calls
      ciclo(4'b0100, 1'b0, 1'b0, 1'b0);
      ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ciclo(4'b0100, 1'b1, 1'b0, 1'b0);
      chk("t5_sat3", 8'({A, B}), 8'd3);
      ciclo(4'b0100, 1'b1, 1'b1, 1'b0);
      chk("t5_ambos", 8'({A, B}), 8'd3);
      for (int i = 0; i < 4; i++) ciclo(4'b0100, 1'b0, 1'b1, 1'b0);
      chk("t5_sat0", 8'({A, B}), 8'd0);
      ciclo(4'b0100, 1'b1, 1'b0, 1'b0);
      ciclo(4'b0001, 1'b0, 1'b0, 1'b0);
      aguarda_fecha("t5_fecha");
      chk("t5_desc", 8'(descendo), 8'd1);
      ciclo(4'b0000, 1'b1, 1'b0, 1'b0);
      chk("t5_mov_ent", 8'({A, B}), 8'd1);
      ciclo(4'b0000, 1'b0, 1'b1, 1'b0);
      chk("t5_mov_sai", 8'({A, B}), 8'd1);
      aguarda_porta("t5_chega");
      chk("t5_f0", 8'(andar), 8'd0);
      aguarda_fecha("t5_fecha0");

      // 3: SCAN order 1, 3, then 0
      ciclo(4'b1010, 1'b0, 1'b0, 1'b0);
      aguarda_porta("t3_p1");
      chk("t3_f1", 8'(andar), 8'd1);
      aguarda_fecha("t3_s1");
      chk("t3_sobe", 8'(subindo), 8'd1);
      ciclo(4'b0001, 1'b0, 1'b0, 1'b0);
      aguarda_porta("t3_p3");
      chk("t3_f3", 8'(andar), 8'd3);
      aguarda_fecha("t3_s3");
      chk("t3_desce", 8'(descendo), 8'd1);
      aguarda_porta("t3_p0");
      chk("t3_f0", 8'(andar), 8'd0);
      aguarda_fecha("t3_s0");
      chk("t3_parado", 8'({subindo, descendo}), 8'd0);

      // 6: reset mid-travel between floors 1 and 2
      ciclo(4'b1000, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 50 && andar != 2'd1; n++) ciclo(4'b0000, 1'b0, 1'b0, 1'b0);
      ocioso(2);
      chk("t6_f1", 8'(andar), 8'd1);
      chk("t6_pend", 8'(pendentes), 8'b1000);
      ciclo(4'b0000, 1'b0, 1'b0, 1'b1);
      chk("t6_andar", 8'(andar), 8'd0);
      chk("t6_pend0", 8'(pendentes), 8'd0);
      chk("t6_estado", 8'({porta_aberta, subindo, descendo}), 8'd0);
      chk("t6_pessoas", 8'({A, B}), 8'd0);
      chk("t6_mux", 8'(controle_Mux), 8'd0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] ch;
         for (int i = 0; i < 4; i++) ch[i] = ($urandom_range(0, 11) == 0);
         ciclo(ch, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 499) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
